alu_op_sequencer: RTL and testbench

//  Front-end controller for the ALU sub-units (arith, logic, compare, shift). Accepts one command per

---
 rtl/alu_seq_pkg.sv | 16 +
 rtl/alu_op_sequencer_if.sv | 26 ++
 rtl/alu_seq_decode.sv | 46 ++++
 rtl/alu_op_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer: FSM state encoding and sub-unit codes.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  localparam logic [1:0] UNIT_ARITH = 2'b00;
  localparam logic [1:0] UNIT_LOGIC = 2'b01;
  localparam logic [1:0] UNIT_CMP   = 2'b10;
  localparam logic [1:0] UNIT_SHIFT = 2'b11;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command/response handshake bundle of the ALU op sequencer.
interface alu_op_sequencer_if #(
  parameter int unsigned IN_DATA_WIDTH  = 16,
  parameter int unsigned OUT_DATA_WIDTH = 16
);
  logic                      CMD_VALID;
  logic                      CMD_READY;
  logic [IN_DATA_WIDTH-1:0]  CMD_A;
  logic [IN_DATA_WIDTH-1:0]  CMD_B;
  logic [3:0]                CMD_FUN;
  logic                      RSP_VALID;
  logic                      RSP_READY;
  logic [OUT_DATA_WIDTH-1:0] RSP_DATA;
  logic [1:0]                RSP_UNIT;
  logic                      RSP_ERR;

  modport master (
    output CMD_VALID, CMD_A, CMD_B, CMD_FUN, RSP_READY,
    input  CMD_READY, RSP_VALID, RSP_DATA, RSP_UNIT, RSP_ERR
  );

  modport slave (
    input  CMD_VALID, CMD_A, CMD_B, CMD_FUN, RSP_READY,
    output CMD_READY, RSP_VALID, RSP_DATA, RSP_UNIT, RSP_ERR
  );
endinterface

// File: rtl/alu_seq_decode.sv
// Unit code -> one-hot enable vector, plus selection of that unit's flag and result.
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int unsigned OUT_DATA_WIDTH = 16
) (
  input  logic [1:0]                unit_sel,
  input  logic [3:0]                flag_vec,
  input  logic [OUT_DATA_WIDTH-1:0] arith_out,
  input  logic [OUT_DATA_WIDTH-1:0] logic_out,
  input  logic [OUT_DATA_WIDTH-1:0] cmp_out,
  input  logic [OUT_DATA_WIDTH-1:0] shift_out,
  output logic [3:0]                enable_vec,
  output logic                      sel_flag,
  output logic [OUT_DATA_WIDTH-1:0] sel_data
);

  always_comb begin
    enable_vec = 4'b0000;
    sel_flag   = 1'b0;
    sel_data   = '0;
    unique case (unit_sel)
      UNIT_ARITH: begin
        enable_vec = 4'b0001;
        sel_flag   = flag_vec[0];
        sel_data   = arith_out;
      end
      UNIT_LOGIC: begin
        enable_vec = 4'b0010;
        sel_flag   = flag_vec[1];
        sel_data   = logic_out;
      end
      UNIT_CMP: begin
        enable_vec = 4'b0100;
        sel_flag   = flag_vec[2];
        sel_data   = cmp_out;
      end
      UNIT_SHIFT: begin
        enable_vec = 4'b1000;
        sel_flag   = flag_vec[3];
        sel_data   = shift_out;
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one command at a time to an ALU sub-unit and returns its result on a response port.
// Optional WAIT watchdog enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned IN_DATA_WIDTH  = 16,
  parameter int unsigned OUT_DATA_WIDTH = 16,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  alu_op_sequencer_if.slave         bus,
  output logic [IN_DATA_WIDTH-1:0]  A,
  output logic [IN_DATA_WIDTH-1:0]  B,
  output logic [1:0]                ALU_FUN,
  output logic                      Arith_Enable,
  output logic                      Logic_Enable,
  output logic                      CMP_Enable,
  output logic                      Shift_Enable,
  input  logic [OUT_DATA_WIDTH-1:0] Arith_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] Logic_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] CMP_OUT,
  input  logic [OUT_DATA_WIDTH-1:0] Shift_OUT,
  input  logic                      Arith_Flag,
  input  logic                      Logic_Flag,
  input  logic                      CMP_Flag,
  input  logic                      Shift_Flag
);

  state_e                    state_q, state_d;
  logic [1:0]                unit_q;
  logic [3:0]                enable_vec;
  logic                      sel_flag;
  logic [OUT_DATA_WIDTH-1:0] sel_data;
  logic [OUT_DATA_WIDTH-1:0] rsp_data_q;
  logic [1:0]                rsp_unit_q;
  logic                      rsp_err_q;
  logic                      timeout;
  logic                      accept, capture, rsp_done;

  alu_seq_decode #(
    .OUT_DATA_WIDTH (OUT_DATA_WIDTH)
  ) u_decode (
    .unit_sel   (unit_q),
    .flag_vec   ({Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag}),
    .arith_out  (Arith_OUT),
    .logic_out  (Logic_OUT),
    .cmp_out    (CMP_OUT),
    .shift_out  (Shift_OUT),
    .enable_vec (enable_vec),
    .sel_flag   (sel_flag),
    .sel_data   (sel_data)
  );

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wait_cnt_q;

  // Counts cycles spent in WAIT; held at zero elsewhere so each WAIT entry starts fresh.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wait_cnt_q <= '0;
    end else if (state_q != StWait) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // A flag arriving in the expiry cycle takes priority over the timeout.
  assign timeout = (state_q == StWait) && !sel_flag &&
                   (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign accept   = (state_q == StIdle) && bus.CMD_VALID;
  assign capture  = (state_q == StWait) && (sel_flag || timeout);
  assign rsp_done = (state_q == StResp) && bus.RSP_READY;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (capture) state_d = StResp;
      StResp:  if (rsp_done) state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.CMD_READY = (state_q == StIdle);
    bus.RSP_VALID = (state_q == StResp);
    bus.RSP_DATA  = rsp_data_q;
    bus.RSP_UNIT  = rsp_unit_q;
    bus.RSP_ERR   = rsp_err_q;
    Arith_Enable  = 1'b0;
    Logic_Enable  = 1'b0;
    CMP_Enable    = 1'b0;
    Shift_Enable  = 1'b0;
    if (state_q == StIssue) begin
      {Shift_Enable, CMP_Enable, Logic_Enable, Arith_Enable} = enable_vec;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      A          <= '0;
      B          <= '0;
      ALU_FUN    <= '0;
      unit_q     <= UNIT_ARITH;
      rsp_data_q <= '0;
      rsp_unit_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        A       <= bus.CMD_A;
        B       <= bus.CMD_B;
        ALU_FUN <= bus.CMD_FUN[1:0];
        unit_q  <= bus.CMD_FUN[3:2];
      end
      if (capture) begin
        rsp_data_q <= sel_flag ? sel_data : '0;
        rsp_unit_q <= unit_q;
        rsp_err_q  <= !sel_flag;
      end else if (rsp_done) begin
        rsp_err_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer: emulated sub-units plus a transaction-level expectation.
module tb_alu_op_sequencer;

  localparam int unsigned IDW = 16;
  localparam int unsigned ODW = 16;
  localparam int unsigned TO  = 8;
`ifdef ALU_SEQ_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  alu_op_sequencer_if #(.IN_DATA_WIDTH(IDW), .OUT_DATA_WIDTH(ODW)) bus ();

  logic [IDW-1:0]        a_out, b_out;
  logic [1:0]            alu_fun;
  logic [3:0]            en;
  logic [3:0][ODW-1:0]   unit_out;
  logic [3:0]            flags;

  alu_op_sequencer #(
    .IN_DATA_WIDTH  (IDW),
    .OUT_DATA_WIDTH (ODW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .bus          (bus),
    .A            (a_out),
    .B            (b_out),
    .ALU_FUN      (alu_fun),
    .Arith_Enable (en[0]),
    .Logic_Enable (en[1]),
    .CMP_Enable   (en[2]),
    .Shift_Enable (en[3]),
    .Arith_OUT    (unit_out[0]),
    .Logic_OUT    (unit_out[1]),
    .CMP_OUT      (unit_out[2]),
    .Shift_OUT    (unit_out[3]),
    .Arith_Flag   (flags[0]),
    .Logic_Flag   (flags[1]),
    .CMP_Flag     (flags[2]),
    .Shift_Flag   (flags[3])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Non-selected units chatter randomly (or all high when others_hi) to prove they are ignored.
  task automatic drive_units(input logic [1:0] u, input logic sel_flag,
                             input logic [ODW-1:0] sel_val, input logic others_hi);
    for (int j = 0; j < 4; j++) begin
      unit_out[j] = ODW'($urandom);
      flags[j]    = others_hi ? 1'b1 : 1'($urandom_range(0, 1));
    end
    flags[u] = sel_flag;
    if (sel_flag) unit_out[u] = sel_val;
  endtask

  task automatic drive_cmd(input logic [3:0] fun, input logic [IDW-1:0] a, input logic [IDW-1:0] b);
    bus.CMD_VALID = 1'b1;
    bus.CMD_FUN   = fun;
    bus.CMD_A     = a;
    bus.CMD_B     = b;
  endtask

  // One full transaction; during backpressure the next command is already presented.
  task automatic run_op(input logic [3:0] fun, input logic [IDW-1:0] a, input logic [IDW-1:0] b,
                        input logic [ODW-1:0] res, input int dly, input int stall,
                        input logic [3:0] nfun, input logic [IDW-1:0] na,
                        input logic [IDW-1:0] nb);
    logic [1:0]     u;
    logic [3:0]     exp_en;
    bit             err_exp;
    int             nwait;
    int             guard;
    logic [ODW-1:0] exp_data;
    u        = fun[3:2];
    exp_en   = 4'b0001 << u;
    err_exp  = TimeoutOn && (dly > int'(TO));
    nwait    = err_exp ? int'(TO) : dly;
    exp_data = err_exp ? '0 : res;

    drive_cmd(fun, a, b);
    guard = 0;
    while (bus.CMD_READY !== 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    check_eq("accept_in_time", 32'(guard < 20), 32'd1);

    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    bus.CMD_FUN   = 4'($urandom);
    bus.CMD_A     = IDW'($urandom);
    bus.CMD_B     = IDW'($urandom);
    drive_units(u, 1'b0, '0, 1'b0);
    check_eq("issue_enable", 32'(en), 32'(exp_en));
    check_eq("issue_a", 32'(a_out), 32'(a));
    check_eq("issue_b", 32'(b_out), 32'(b));
    check_eq("issue_alu_fun", 32'(alu_fun), 32'(fun[1:0]));
    check_eq("issue_cmd_ready", 32'(bus.CMD_READY), 32'd0);
    check_eq("issue_rsp_valid", 32'(bus.RSP_VALID), 32'd0);

    for (int k = 1; k <= nwait; k++) begin
      @(negedge CLK);
      check_eq("wait_enable", 32'(en), 32'd0);
      check_eq("wait_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
      drive_units(u, 1'(k == dly), res, 1'(k < dly));
    end

    @(negedge CLK);
    drive_units(u, 1'($urandom_range(0, 1)), ODW'($urandom), 1'b0);
    check_eq("rsp_valid", 32'(bus.RSP_VALID), 32'd1);
    check_eq("rsp_data", 32'(bus.RSP_DATA), 32'(exp_data));
    check_eq("rsp_unit", 32'(bus.RSP_UNIT), 32'(u));
    check_eq("rsp_err", 32'(bus.RSP_ERR), 32'(err_exp));
    check_eq("rsp_cmd_ready", 32'(bus.CMD_READY), 32'd0);

    for (int s = 0; s < stall; s++) begin
      bus.RSP_READY = 1'b0;
      drive_cmd(nfun, na, nb);
      @(negedge CLK);
      drive_units(u, 1'($urandom_range(0, 1)), ODW'($urandom), 1'b0);
      check_eq("hold_valid", 32'(bus.RSP_VALID), 32'd1);
      check_eq("hold_data", 32'(bus.RSP_DATA), 32'(exp_data));
      check_eq("hold_unit", 32'(bus.RSP_UNIT), 32'(u));
      check_eq("hold_err", 32'(bus.RSP_ERR), 32'(err_exp));
      check_eq("hold_cmd_ready", 32'(bus.CMD_READY), 32'd0);
    end

    drive_cmd(nfun, na, nb);
    bus.RSP_READY = 1'b1;
    @(negedge CLK);
    bus.RSP_READY = 1'b0;
    check_eq("done_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    check_eq("done_rsp_err", 32'(bus.RSP_ERR), 32'd0);
    check_eq("done_cmd_ready", 32'(bus.CMD_READY), 32'd1);
  endtask

  // Abort an op in WAIT with an asynchronous reset; nothing may come back afterwards.
  task automatic mid_reset(input logic [3:0] fun, input logic [IDW-1:0] a, input logic [IDW-1:0] b);
    int guard;
    drive_cmd(fun, a, b);
    guard = 0;
    while (bus.CMD_READY !== 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    check_eq("rst_accept_in_time", 32'(guard < 20), 32'd1);
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    flags = 4'b0000;
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    check_eq("rst_async_enable", 32'(en), 32'd0);
    check_eq("rst_async_cmd_ready", 32'(bus.CMD_READY), 32'd1);
    check_eq("rst_async_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    @(negedge CLK);
    RST   = 1'b1;
    flags = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check_eq("post_rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
      check_eq("post_rst_enable", 32'(en), 32'd0);
      check_eq("post_rst_cmd_ready", 32'(bus.CMD_READY), 32'd1);
    end
    flags = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]     fun, nfun;
    logic [IDW-1:0] a, b, na, nb;
    logic [ODW-1:0] res;
    int             dly, stall;

    bus.CMD_VALID = 1'b0;
    bus.CMD_FUN   = '0;
    bus.CMD_A     = '0;
    bus.CMD_B     = '0;
    bus.RSP_READY = 1'b0;
    unit_out      = '0;
    flags         = '0;

    repeat (3) @(negedge CLK);
    check_eq("reset_enable", 32'(en), 32'd0);
    check_eq("reset_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
    check_eq("reset_rsp_err", 32'(bus.RSP_ERR), 32'd0);
    check_eq("reset_a", 32'(a_out), 32'd0);
    check_eq("reset_b", 32'(b_out), 32'd0);
    check_eq("reset_alu_fun", 32'(alu_fun), 32'd0);
    check_eq("reset_rsp_data", 32'(bus.RSP_DATA), 32'd0);
    check_eq("reset_rsp_unit", 32'(bus.RSP_UNIT), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check_eq("reset_cmd_ready", 32'(bus.CMD_READY), 32'd1);

    // Directed first op: logic NAND with a 5-cycle response stall.
    fun = 4'b0110;
    a   = 16'hF0F0;
    b   = 16'hFF00;
    res = 16'h0FFF;

    for (int i = 0; i < 40; i++) begin
      nfun  = (i == 0) ? 4'b0001 : 4'($urandom);
      na    = IDW'($urandom);
      nb    = IDW'($urandom);
      dly   = TimeoutOn ? $urandom_range(1, TO + 3) : $urandom_range(1, 6);
      stall = $urandom_range(0, 3);
      if (i == 0) begin
        dly   = 1;
        stall = 5;
      end
      if (i == 1) dly = 3;
      if (i == 2 && TimeoutOn) dly = TO + 5;
      if (i == 3 && TimeoutOn) dly = TO;
      if (i == 10) mid_reset(fun, a, b);
      else run_op(fun, a, b, res, dly, stall, nfun, na, nb);
      fun = nfun;
      a   = na;
      b   = nb;
      res = ODW'($urandom);
    end
    bus.CMD_VALID = 1'b0;
    repeat (2) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
